// File: rtl/stage2_seq_tracker_pkg.sv
// Shared encodings and default sizing for the stage-2 sequence tracker.
package stage2_seq_tracker_pkg;

  localparam int CH_NUM_DEF       = 4;
  localparam int SEQ_BITS_DEF     = 32;
  localparam int GAP_CNT_BITS_DEF = 16;

  // Result code reported with every accepted message
  typedef enum logic [1:0] {
    ST_FIRST    = 2'd0,
    ST_IN_ORDER = 2'd1,
    ST_GAP      = 2'd2,
    ST_STALE    = 2'd3
  } seq_status_e;

endpackage

// File: rtl/stage2_seq_chan.sv
// One feed channel: sync state, expected sequence number, gap counter,
// and the classification of an incoming sequence number against them.
module stage2_seq_chan
  import stage2_seq_tracker_pkg::*;
#(
  parameter int SEQ_BITS     = SEQ_BITS_DEF,
  parameter int GAP_CNT_BITS = GAP_CNT_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hit,
  input  logic [SEQ_BITS-1:0]     seq,
  input  logic                    sync,
  output seq_status_e             status,
  output logic [SEQ_BITS-1:0]     gap_len,
  output logic [GAP_CNT_BITS-1:0] gap_cnt_nxt
);

  logic                    synced;
  logic [SEQ_BITS-1:0]     exp_q;
  logic [SEQ_BITS-1:0]     diff;
  logic [GAP_CNT_BITS-1:0] gap_cnt_q;

  // Classify: forward distance below half the number space is a gap,
  // anything at or beyond half is treated as old (stale) traffic.
  always_comb begin
    diff    = seq - exp_q;
    status  = ST_FIRST;
    gap_len = '0;
    if (synced) begin
      if (diff == '0) begin
        status = ST_IN_ORDER;
      end else if (!diff[SEQ_BITS-1]) begin
        status  = ST_GAP;
        gap_len = diff;
      end else begin
        status = ST_STALE;
      end
    end
  end

  // Next counter value is exported so the stat read can see this edge's increment
  assign gap_cnt_nxt = (hit && status == ST_GAP && gap_cnt_q != '1)
                     ? gap_cnt_q + GAP_CNT_BITS'(1) : gap_cnt_q;

  // Channel state update; a resync in the same cycle as a message wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      synced    <= 1'b0;
      exp_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_nxt;
      if (hit) begin
        synced <= 1'b1;
        case (status)
          ST_FIRST, ST_GAP: exp_q <= seq + SEQ_BITS'(1);
          ST_IN_ORDER:      exp_q <= exp_q + SEQ_BITS'(1);
          default:          exp_q <= exp_q;
        endcase
      end
      if (sync) synced <= 1'b0;
    end
  end

endmodule

// File: rtl/stage2_seq_tracker.sv
// Per-channel sequence tracker: decodes the message channel, classifies it
// in the owning channel, registers the result, and serves gap statistics.
module stage2_seq_tracker
  import stage2_seq_tracker_pkg::*;
#(
  parameter int CH_NUM       = CH_NUM_DEF,
  parameter int SEQ_BITS     = SEQ_BITS_DEF,
  parameter int GAP_CNT_BITS = GAP_CNT_BITS_DEF,
  localparam int CH_BITS     = $clog2(CH_NUM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    msg_valid,
  input  logic [CH_BITS-1:0]      msg_ch,
  input  logic [SEQ_BITS-1:0]     msg_seq,
  input  logic                    sync_req,
  input  logic [CH_BITS-1:0]      sync_ch,
  output logic                    out_valid,
  output logic [CH_BITS-1:0]      out_ch,
  output logic [SEQ_BITS-1:0]     out_seq,
  output logic [1:0]              out_status,
  output logic [SEQ_BITS-1:0]     out_gap_len,
  input  logic [CH_BITS-1:0]      stat_ch,
  output logic [GAP_CNT_BITS-1:0] stat_gap_cnt
);

  logic [CH_NUM-1:0]                   hit;
  logic [CH_NUM-1:0]                   sync;
  logic [CH_NUM-1:0][1:0]              st_vec;
  logic [CH_NUM-1:0][SEQ_BITS-1:0]     gap_vec;
  logic [CH_NUM-1:0][GAP_CNT_BITS-1:0] cnt_nxt_vec;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    seq_status_e st;

    assign hit[g]    = msg_valid && (msg_ch == CH_BITS'(g));
    assign sync[g]   = sync_req && (sync_ch == CH_BITS'(g));
    assign st_vec[g] = st;

    stage2_seq_chan #(
      .SEQ_BITS     (SEQ_BITS),
      .GAP_CNT_BITS (GAP_CNT_BITS)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .hit         (hit[g]),
      .seq         (msg_seq),
      .sync        (sync[g]),
      .status      (st),
      .gap_len     (gap_vec[g]),
      .gap_cnt_nxt (cnt_nxt_vec[g])
    );
  end

  // Result register: one strobe per message, one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_seq     <= '0;
      out_status  <= ST_FIRST;
      out_gap_len <= '0;
    end else begin
      out_valid <= msg_valid;
      if (msg_valid) begin
        out_ch      <= msg_ch;
        out_seq     <= msg_seq;
        out_status  <= st_vec[msg_ch];
        out_gap_len <= gap_vec[msg_ch];
      end
    end
  end

  // Stat read: samples the post-edge counter value of the selected channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_gap_cnt <= '0;
    else     stat_gap_cnt <= cnt_nxt_vec[stat_ch];
  end

endmodule

// File: tb/tb_stage2_seq_tracker.sv
// Directed vector bench for stage2_seq_tracker (4 channels, 32-bit seq, 2-bit gap counters).
module tb_stage2_seq_tracker;

  localparam int SEQ_BITS = 32;
  localparam int GCB      = 2;
  localparam bit [1:0] F = 2'd0, IO = 2'd1, G = 2'd2, S = 2'd3;

  logic            clk = 1'b0;
  logic            rst;
  logic            msg_valid;
  logic [1:0]      msg_ch;
  logic [31:0]     msg_seq;
  logic            sync_req;
  logic [1:0]      sync_ch;
  logic            out_valid;
  logic [1:0]      out_ch;
  logic [31:0]     out_seq;
  logic [1:0]      out_status;
  logic [31:0]     out_gap_len;
  logic [1:0]      stat_ch;
  logic [GCB-1:0]  stat_gap_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage2_seq_tracker #(
    .CH_NUM       (4),
    .SEQ_BITS     (SEQ_BITS),
    .GAP_CNT_BITS (GCB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .msg_valid    (msg_valid),
    .msg_ch       (msg_ch),
    .msg_seq      (msg_seq),
    .sync_req     (sync_req),
    .sync_ch      (sync_ch),
    .out_valid    (out_valid),
    .out_ch       (out_ch),
    .out_seq      (out_seq),
    .out_status   (out_status),
    .out_gap_len  (out_gap_len),
    .stat_ch      (stat_ch),
    .stat_gap_cnt (stat_gap_cnt)
  );

  typedef struct {
    bit        v;
    bit [1:0]  ch;
    bit [31:0] seq;
    bit        s;
    bit [1:0]  sch;
    bit [1:0]  stch;
    bit        ev;
    bit [1:0]  est;
    bit [31:0] egap;
    bit [1:0]  estat;
  } vec_t;

  vec_t vecs[$];
  vec_t post[$];

  function automatic vec_t mk(bit v, bit [1:0] ch, bit [31:0] seq, bit s, bit [1:0] sch,
                              bit [1:0] stch, bit ev, bit [1:0] est, bit [31:0] egap,
                              bit [1:0] estat);
    vec_t r;
    r.v = v; r.ch = ch; r.seq = seq; r.s = s; r.sch = sch; r.stch = stch;
    r.ev = ev; r.est = est; r.egap = egap; r.estat = estat;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    msg_valid = v.v; msg_ch = v.ch; msg_seq = v.seq;
    sync_req = v.s; sync_ch = v.sch; stat_ch = v.stch;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.ev));
    if (v.ev) begin
      chk($sformatf("v%0d out_ch", idx), 32'(out_ch), 32'(v.ch));
      chk($sformatf("v%0d out_seq", idx), out_seq, v.seq);
      chk($sformatf("v%0d out_status", idx), 32'(out_status), 32'(v.est));
      chk($sformatf("v%0d out_gap_len", idx), out_gap_len, v.egap);
    end
    chk($sformatf("v%0d stat_gap_cnt", idx), 32'(stat_gap_cnt), 32'(v.estat));
  endtask

  initial begin
    // basic in-order run on ch0
    vecs.push_back(mk(1, 0, 100, 0, 0, 0, 1, F,  0, 0));
    vecs.push_back(mk(1, 0, 101, 0, 0, 0, 1, IO, 0, 0));
    vecs.push_back(mk(1, 0, 102, 0, 0, 0, 1, IO, 0, 0));
    // ch1 gap of 5 from exp=10
    vecs.push_back(mk(1, 1, 9,   0, 0, 1, 1, F,  0, 0));
    vecs.push_back(mk(1, 1, 15,  0, 0, 1, 1, G,  5, 1));
    vecs.push_back(mk(1, 1, 16,  0, 0, 1, 1, IO, 0, 1));
    // ch2 stale then in-order
    vecs.push_back(mk(1, 2, 49,  0, 0, 2, 1, F,  0, 0));
    vecs.push_back(mk(1, 2, 40,  0, 0, 2, 1, S,  0, 0));
    vecs.push_back(mk(1, 2, 50,  0, 0, 2, 1, IO, 0, 0));
    // idle cycle: no strobe
    vecs.push_back(mk(0, 0, 0,   0, 0, 1, 0, F,  0, 1));
    // ch3 wrap-around
    vecs.push_back(mk(1, 3, 32'hFFFF_FFFF, 0, 0, 3, 1, F,  0, 0));
    vecs.push_back(mk(1, 3, 32'h0000_0000, 0, 0, 3, 1, IO, 0, 0));
    vecs.push_back(mk(1, 3, 32'h0000_0002, 0, 0, 3, 1, G,  1, 1));
    // ch2 (exp=51): distance exactly half-space is stale, one less is a gap
    vecs.push_back(mk(1, 2, 32'h8000_0033, 0, 0, 2, 1, S,  0, 0));
    vecs.push_back(mk(1, 2, 32'h8000_0032, 0, 0, 2, 1, G,  32'h7FFF_FFFF, 1));
    vecs.push_back(mk(1, 2, 32'h8000_0033, 0, 0, 2, 1, IO, 0, 1));
    // ch0 untouched by other channels' traffic
    vecs.push_back(mk(1, 0, 103, 0, 0, 0, 1, IO, 0, 0));
    // resync: alone, then coincident with a message on the same channel
    vecs.push_back(mk(0, 0, 0,   1, 0, 0, 0, F,  0, 0));
    vecs.push_back(mk(1, 0, 6,   0, 0, 0, 1, F,  0, 0));
    vecs.push_back(mk(1, 0, 7,   1, 0, 0, 1, IO, 0, 0));
    vecs.push_back(mk(1, 0, 99,  0, 0, 0, 1, F,  0, 0));
    // sync ch1 while messaging ch0; ch1 counter must survive
    vecs.push_back(mk(1, 0, 100, 1, 1, 1, 1, IO, 0, 1));
    // ch1 gap counter saturation at 3
    vecs.push_back(mk(1, 1, 200, 0, 0, 1, 1, F,  0, 1));
    vecs.push_back(mk(1, 1, 203, 0, 0, 1, 1, G,  2, 2));
    vecs.push_back(mk(1, 1, 205, 0, 0, 1, 1, G,  1, 3));
    vecs.push_back(mk(1, 1, 210, 0, 0, 1, 1, G,  4, 3));
    vecs.push_back(mk(1, 1, 220, 0, 0, 1, 1, G,  9, 3));
    vecs.push_back(mk(1, 1, 221, 0, 0, 1, 1, IO, 0, 3));
    // after a mid-stream reset every channel restarts with FIRST
    post.push_back(mk(1, 1, 222, 0, 0, 1, 1, F,  0, 0));
    post.push_back(mk(1, 2, 32'h8000_0034, 0, 0, 2, 1, F, 0, 0));
    post.push_back(mk(1, 1, 223, 0, 0, 1, 1, IO, 0, 0));

    rst = 1'b1; msg_valid = 1'b0; msg_ch = '0; msg_seq = '0;
    sync_req = 1'b0; sync_ch = '0; stat_ch = '0;
    #3;
    chk("reset out_valid",   32'(out_valid), 0);
    chk("reset out_status",  32'(out_status), 0);
    chk("reset out_gap_len", out_gap_len, 0);
    chk("reset stat",        32'(stat_gap_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // asynchronous reset in the middle of a burst
    msg_valid = 1'b1; msg_ch = 2'd1; msg_seq = 32'd222; stat_ch = 2'd1;
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid",   32'(out_valid), 0);
    chk("async rst out_ch",      32'(out_ch), 0);
    chk("async rst out_seq",     out_seq, 0);
    chk("async rst out_status",  32'(out_status), 0);
    chk("async rst out_gap_len", out_gap_len, 0);
    chk("async rst stat",        32'(stat_gap_cnt), 0);
    msg_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post rst out_valid", 32'(out_valid), 0);

    foreach (post[i]) run_vec(100 + i, post[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
